tlul_mem_responder: RTL and testbench



---
 rtl/tlul_mem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_tlul_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_mem_responder.sv
// -----------------------------------------------------------------------------
// tlul_mem_responder
//
// TL-UL device endpoint in front of a word-addressed single-port memory.
// Decodes Get / PutFullData / PutPartialData, rejects malformed requests
// with d_error, drives the memory combinationally from the A channel and
// returns responses strictly in acceptance order through a response FIFO.
//
// Optional feature macro: TLUL_MEM_RESPONDER_RANGE_CHK_EN
//   defined   -> addresses with a_address[31:MemAw+2] != 0 are error requests
//   undefined -> upper address bits are ignored (addresses alias)
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   tl_i      in   TL-UL A channel + d_ready
//   tl_o      out  TL-UL D channel + a_ready
//   req_o     out  memory request
//   we_o      out  memory write enable
//   addr_o    out  memory word address (a_address[MemAw+1:2])
//   wdata_o   out  write data
//   wmask_o   out  bit write mask (byte-expanded a_mask)
//   gnt_i     in   memory accepts req_o this cycle
//   rvalid_i  in   read data valid, one cycle after a granted read
//   rdata_i   in   read data
//
// Handshake: a transfer on either channel happens in a cycle where valid and
// ready are both high at the rising clock edge. Once d_valid is high it stays
// high with all D fields stable until d_ready is seen; a_ready may depend
// combinationally on the A fields and on gnt_i.
// -----------------------------------------------------------------------------
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter int MemAw       = 10,
  parameter int Outstanding = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  tl_h2d_t          tl_i,
  output tl_d2h_t          tl_o,
  output logic             req_o,
  output logic             we_o,
  output logic [MemAw-1:0] addr_o,
  output logic [31:0]      wdata_o,
  output logic [31:0]      wmask_o,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  input  logic [31:0]      rdata_i
);

  localparam int PtrW = $clog2(Outstanding);
  localparam int CntW = PtrW + 1;

  // ---------------------------------------------------------------------------
  // Response FIFO storage
  // ---------------------------------------------------------------------------
  logic [7:0]      r_src     [Outstanding];
  logic [1:0]      r_size    [Outstanding];
  logic [2:0]      r_op      [Outstanding];
  logic            r_err     [Outstanding];
  logic [31:0]     r_data    [Outstanding];
  logic            r_pending [Outstanding];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  // Tracks the read granted last cycle so its rvalid_i lands in the right slot.
  logic            r_rd_inflight;
  logic [PtrW-1:0] r_rd_slot;
  logic            r_spurious_rvalid;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic        w_is_get;
  logic        w_is_pf;
  logic        w_is_pp;
  logic        w_op_ok;
  logic        w_range_err;
  logic        w_err;
  logic        w_space;
  logic        w_req;
  logic        w_a_ready;
  logic        w_push;
  logic        w_push_rd;
  logic        w_empty;
  logic        w_d_valid;
  logic        w_pop;
  logic [31:0] w_mask_exp;
  logic        w_unused;

  assign w_is_get = (tl_i.a_opcode == Get);
  assign w_is_pf  = (tl_i.a_opcode == PutFullData);
  assign w_is_pp  = (tl_i.a_opcode == PutPartialData);
  assign w_op_ok  = w_is_get || w_is_pf || w_is_pp;

`ifdef TLUL_MEM_RESPONDER_RANGE_CHK_EN
  assign w_range_err = |tl_i.a_address[31:MemAw+2];
  assign w_unused    = ^tl_i.a_param;
`else
  // Upper address bits are deliberately dropped: the memory aliases.
  assign w_range_err = 1'b0;
  assign w_unused    = ^{tl_i.a_param, tl_i.a_address[31:MemAw+2]};
`endif

  assign w_err = !w_op_ok
              || (tl_i.a_address[1:0] != 2'b00)
              || (tl_i.a_size != 2'd2)
              || (w_is_pf && (tl_i.a_mask != 4'hF))
              || w_range_err;

  assign w_mask_exp = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                       {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

  assign w_space = (r_count < CntW'(Outstanding));

  // ---------------------------------------------------------------------------
  // A channel -> memory (combinational path)
  // ---------------------------------------------------------------------------
  assign w_req   = tl_i.a_valid && !w_err && w_space && !rst_i;
  assign req_o   = w_req;
  assign we_o    = w_req && !w_is_get;
  assign addr_o  = w_req ? tl_i.a_address[MemAw+1:2] : '0;
  assign wdata_o = w_req ? tl_i.a_data : '0;
  assign wmask_o = w_req ? w_mask_exp : '0;

  // Error requests never touch memory, so they only need a free FIFO slot.
  assign w_a_ready = !rst_i && w_space && (w_err || gnt_i);
  assign w_push    = tl_i.a_valid && w_a_ready;
  assign w_push_rd = w_push && !w_err && w_is_get;

  // ---------------------------------------------------------------------------
  // D channel
  // ---------------------------------------------------------------------------
  assign w_empty   = (r_count == '0);
  // A pending head (read still waiting for data) blocks everything behind it.
  assign w_d_valid = !rst_i && !w_empty && !r_pending[r_rptr];
  assign w_pop     = w_d_valid && tl_i.d_ready;

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = w_a_ready;
    tl_o.d_valid = w_d_valid;
    if (w_d_valid) begin
      tl_o.d_opcode = r_op[r_rptr];
      tl_o.d_size   = r_size[r_rptr];
      tl_o.d_source = r_src[r_rptr];
      tl_o.d_data   = r_data[r_rptr];
      tl_o.d_error  = r_err[r_rptr];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_count           <= '0;
      r_rd_inflight     <= 1'b0;
      r_rd_slot         <= '0;
      r_spurious_rvalid <= 1'b0;
      for (int i = 0; i < Outstanding; i++) begin
        r_src[i]     <= '0;
        r_size[i]    <= '0;
        r_op[i]      <= '0;
        r_err[i]     <= 1'b0;
        r_data[i]    <= '0;
        r_pending[i] <= 1'b0;
      end
    end else begin
      // Read data return. The slot of the in-flight read is still occupied,
      // so it can never collide with this cycle's push slot.
      if (rvalid_i) begin
        if (r_rd_inflight) begin
          r_data[r_rd_slot]    <= rdata_i;
          r_pending[r_rd_slot] <= 1'b0;
        end else begin
          r_spurious_rvalid <= 1'b1;
        end
      end

      if (w_push) begin
        r_src[r_wptr]     <= tl_i.a_source;
        r_size[r_wptr]    <= tl_i.a_size;
        r_op[r_wptr]      <= w_is_get ? AccessAckData : AccessAck;
        r_err[r_wptr]     <= w_err;
        r_data[r_wptr]    <= '0;
        r_pending[r_wptr] <= w_push_rd;
        r_wptr            <= r_wptr + 1'b1;
      end

      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      r_count       <= r_count + CntW'(w_push) - CntW'(w_pop);
      r_rd_inflight <= w_push_rd;
      r_rd_slot     <= r_wptr;
    end
  end

endmodule

// File: tb/tb_tlul_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for tlul_mem_responder: directed sequence in one initial block,
// a behavioural memory, and a D-channel monitor that pops an expected-response
// queue. Expected responses are computed from the request and a shadow copy
// of the memory contents kept by the driver.
// -----------------------------------------------------------------------------
module tb_tlul_mem_responder;
  import tlul_pkg::*;

  localparam int MemAw       = 10;
  localparam int Outstanding = 4;
  localparam int RespW       = 46;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  tl_h2d_t          tl_i;
  tl_d2h_t          tl_o;
  logic             req_o;
  logic             we_o;
  logic [MemAw-1:0] addr_o;
  logic [31:0]      wdata_o;
  logic [31:0]      wmask_o;
  logic             gnt_i;
  logic             rvalid_i;
  logic [31:0]      rdata_i;

  tlul_mem_responder #(.MemAw(MemAw), .Outstanding(Outstanding)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .tl_i    (tl_i),
    .tl_o    (tl_o),
    .req_o   (req_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .wmask_o (wmask_o),
    .gnt_i   (gnt_i),
    .rvalid_i(rvalid_i),
    .rdata_i (rdata_i)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memory (one-cycle read latency)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [1 << MemAw];
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic        inj_rvalid = 1'b0;

  always @(posedge clk) begin
    mem_rvalid <= req_o && gnt_i && !we_o;
    mem_rdata  <= mem[addr_o];
    if (req_o && gnt_i && we_o)
      mem[addr_o] <= (mem[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
  end

  assign rvalid_i = mem_rvalid | inj_rvalid;
  assign rdata_i  = mem_rdata;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [RespW-1:0] exp_q[$];
  logic [31:0]      ref_mem [1 << MemAw];
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RespW-1:0] pack_resp(input logic [1:0] size, input logic [2:0] op,
                                                 input logic err, input logic [7:0] src,
                                                 input logic [31:0] data);
    return {size, op, err, src, data};
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  // D-channel monitor: compares each completed response, and checks that a
  // stalled response holds all fields.
  logic             hold = 1'b0;
  logic [RespW-1:0] held = '0;

  always @(negedge clk) begin
    logic [RespW-1:0] got;
    logic [RespW-1:0] e;
    got = pack_resp(tl_o.d_size, tl_o.d_opcode, tl_o.d_error, tl_o.d_source, tl_o.d_data);
    if (rst_i) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("d_hold_valid", tl_o.d_valid, 1'b1);
        chk("d_hold_stable", got, held);
      end
      if (tl_o.d_valid && tl_i.d_ready) begin
        if (exp_q.size() == 0) begin
          chk("d_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("d_resp", got, e);
        end
      end
      hold = tl_o.d_valid && !tl_i.d_ready;
      held = got;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                      input logic exp_err, input bit rand_gnt);
    bit          done;
    logic [9:0]  widx;
    logic [31:0] exp_data;
    logic [2:0]  exp_op;
    done = 0;
    widx = addr[MemAw+1:2];
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = '0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (exp_err) chk("err_no_req", req_o, 1'b0);
      if (tl_o.a_ready) begin
        if (!exp_err) begin
          chk("a_req", req_o, 1'b1);
          chk("a_we", we_o, (op != Get));
          chk("a_addr", addr_o, widx);
          if (op != Get) begin
            chk("a_wmask", wmask_o, expand(mask));
            chk("a_wdata", wdata_o, data);
          end
        end
        exp_op   = (op == Get) ? AccessAckData : AccessAck;
        exp_data = (!exp_err && op == Get) ? ref_mem[widx] : 32'h0;
        exp_q.push_back(pack_resp(size, exp_op, exp_err, src, exp_data));
        if (!exp_err && op != Get)
          ref_mem[widx] = (ref_mem[widx] & ~expand(mask)) | (data & expand(mask));
        done = 1;
      end
      @(posedge clk); #1;
    end
    tl_i.a_valid = 1'b0;
    gnt_i        = 1'b1;
    chk("accept_timeout", done, 1'b1);
  endtask

  task automatic drain();
    for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic range_err;
    int   acc;
`ifdef TLUL_MEM_RESPONDER_RANGE_CHK_EN
    range_err = 1'b1;
`else
    range_err = 1'b0;
`endif
    tl_i         = '0;
    tl_i.d_ready = 1'b1;
    gnt_i        = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_a_ready", tl_o.a_ready, 1'b0);
    chk("rst_d_valid", tl_o.d_valid, 1'b0);
    chk("rst_req", req_o, 1'b0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wmask", wmask_o, 0);
    chk("rst_d_error", tl_o.d_error, 1'b0);
    chk("rst_d_data", tl_o.d_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_count", dut.r_count, 0);
    chk("rst_spurious", dut.r_spurious_rvalid, 1'b0);
    @(posedge clk); #1;

    // PutFullData 0x10, write response one cycle later
    send(PutFullData, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'd3, 1'b0, 0);
    @(negedge clk);
    chk("wr_lat_t1", tl_o.d_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // Get 0x10: data response two cycles after acceptance
    send(Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd5, 1'b0, 0);
    @(negedge clk);
    chk("rd_lat_t1", tl_o.d_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_lat_t2", tl_o.d_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // Error requests: misaligned, bad opcode, short PutFull mask, bad size
    send(Get, 32'h11, 2'd2, 4'hF, 32'h0, 8'd6, 1'b1, 0);
    @(negedge clk);
    chk("err_lat_t1", tl_o.d_valid, 1'b1);
    @(posedge clk); #1;
    send(3'd2, 32'h20, 2'd2, 4'hF, 32'h1, 8'd7, 1'b1, 0);
    send(PutFullData, 32'h20, 2'd2, 4'h7, 32'h1, 8'd8, 1'b1, 0);
    send(Get, 32'h20, 2'd1, 4'hF, 32'h0, 8'd9, 1'b1, 0);
    drain();

    // Back-to-back Get / PutPartial / Get
    send(PutFullData, 32'h20, 2'd2, 4'hF, 32'h11223344, 8'd0, 1'b0, 0);
    send(PutFullData, 32'h0, 2'd2, 4'hF, 32'hCAFEF00D, 8'd0, 1'b0, 0);
    send(Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd1, 1'b0, 0);
    send(PutPartialData, 32'h20, 2'd2, 4'b0011, 32'hAABBCCDD, 8'd2, 1'b0, 0);
    send(Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd3, 1'b0, 0);
    drain();

    // Randomised grant stalls and data
    for (int i = 0; i < 6; i++) begin
      send(PutFullData, 32'h100 + 32'(4 * i), 2'd2, 4'hF, $urandom, 8'(16 + i), 1'b0, 1);
      send(Get, 32'h100 + 32'(4 * i), 2'd2, 4'hF, 32'h0, 8'(32 + i), 1'b0, 1);
    end
    drain();

    // Full FIFO with d_ready low
    tl_i.d_ready = 1'b0;
    send(Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd40, 1'b0, 0);
    send(PutFullData, 32'h30, 2'd2, 4'hF, 32'h55AA55AA, 8'd41, 1'b0, 0);
    send(Get, 32'h30, 2'd2, 4'hF, 32'h0, 8'd42, 1'b0, 0);
    send(Get, 32'h11, 2'd2, 4'hF, 32'h0, 8'd43, 1'b1, 0);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = Get;
    tl_i.a_size    = 2'd2;
    tl_i.a_source  = 8'd44;
    tl_i.a_address = 32'h20;
    tl_i.a_mask    = 4'hF;
    acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (tl_o.a_ready) acc++;
      chk("full_req", req_o, 1'b0);
      @(posedge clk); #1;
    end
    chk("full_no_accept", acc, 0);
    chk("full_count", dut.r_count, Outstanding);
    tl_i.d_ready = 1'b1;
    send(Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd44, 1'b0, 0);
    drain();

    // Out-of-range address: error or alias to word 0
    send(Get, 32'h1000, 2'd2, 4'hF, 32'h0, 8'd7, range_err, 0);
    drain();

    // rvalid with nothing outstanding sets the sticky flag
    inj_rvalid = 1'b1;
    @(posedge clk); #1;
    inj_rvalid = 1'b0;
    @(negedge clk);
    chk("spurious_set", dut.r_spurious_rvalid, 1'b1);
    chk("spurious_no_d", tl_o.d_valid, 1'b0);
    @(posedge clk); #1;

    // Reset with two reads outstanding
    tl_i.d_ready = 1'b0;
    send(Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd1, 1'b0, 0);
    send(Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd2, 1'b0, 0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_q.delete();
    inj_rvalid = 1'b1;
    @(negedge clk);
    chk("post_rst_count", dut.r_count, 0);
    chk("post_rst_spurious", dut.r_spurious_rvalid, 1'b0);
    @(posedge clk); #1;
    inj_rvalid   = 1'b0;
    tl_i.d_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("post_rst_no_d", tl_o.d_valid, 1'b0);
      @(posedge clk); #1;
    end
    chk("post_rst_count2", dut.r_count, 0);
    send(Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd4, 1'b0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
